bomb_scheduler: RTL and testbench

- Owns a pool of NUM_SLOTS bomb slots and arbitrates bomb-placement requests from two players.
- Sequences each slot's fuse and explosion lifetime on frame ticks.
- Publishes per-slot state, owner and tile position to the sprite/draw logic and the collision logic.
- Sits between the keyboard/player controllers and the renderer, replacing per-bomb standalone timers.

---
 rtl/bomb_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_bomb_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bomb_scheduler.sv
// Pool of NUM_SLOTS bomb slots: two-player placement arbitration plus frame-tick
// fuse/explosion sequencing. Define CHAIN_EN to let chain_hit detonate a fusing bomb.
module bomb_scheduler #(
    parameter int NUM_SLOTS      = 4,
    parameter int MAX_PER_PLAYER = 2,
    parameter int FUSE_FRAMES    = 80,
    parameter int EXPLODE_FRAMES = 10,
    parameter int POS_W          = 5
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       frame_tick,
    input  logic [1:0]                 req,
    input  logic [POS_W-1:0]           req_x0,
    input  logic [POS_W-1:0]           req_y0,
    input  logic [POS_W-1:0]           req_x1,
    input  logic [POS_W-1:0]           req_y1,
    output logic [1:0]                 grant,
    output logic [1:0]                 deny,
    output logic [2*NUM_SLOTS-1:0]     slot_state,
    output logic [NUM_SLOTS-1:0]       slot_owner,
    output logic [POS_W*NUM_SLOTS-1:0] slot_x,
    output logic [POS_W*NUM_SLOTS-1:0] slot_y,
    output logic [NUM_SLOTS-1:0]       explode_start,
    input  logic [NUM_SLOTS-1:0]       chain_hit
);
    localparam int LIVE_W = $clog2(NUM_SLOTS + 1);
    localparam logic [LIVE_W-1:0] LIVE_MAX  = LIVE_W'(MAX_PER_PLAYER);
    localparam logic [LIVE_W-1:0] LIVE_ONE  = LIVE_W'(1);
    localparam logic [7:0]        FUSE_LOAD = 8'(FUSE_FRAMES - 1);
    localparam logic [7:0]        EXP_LOAD  = 8'(EXPLODE_FRAMES - 1);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_FUSE    = 2'd1,
        S_EXPLODE = 2'd2,
        S_DONE    = 2'd3
    } slot_state_t;

    slot_state_t          r_state [NUM_SLOTS];
    slot_state_t          w_state_n [NUM_SLOTS];
    logic [7:0]           r_cnt [NUM_SLOTS];
    logic [7:0]           w_cnt_n [NUM_SLOTS];
    logic                 r_owner [NUM_SLOTS];
    logic                 w_owner_n [NUM_SLOTS];
    logic [POS_W-1:0]     r_x [NUM_SLOTS];
    logic [POS_W-1:0]     w_x_n [NUM_SLOTS];
    logic [POS_W-1:0]     r_y [NUM_SLOTS];
    logic [POS_W-1:0]     w_y_n [NUM_SLOTS];
    logic [LIVE_W-1:0]    r_live [2];
    logic [LIVE_W-1:0]    w_live_n [2];
    logic [LIVE_W-1:0]    w_dec [2];
    logic [NUM_SLOTS-1:0] r_explode, w_explode_n;
    logic [NUM_SLOTS-1:0] w_alloc, w_chain;
    logic [1:0]           r_armed, w_armed_n, r_grant, w_grant_n, r_deny, w_deny_n, w_elig;
    logic                 r_rr, w_rr_n;
    logic                 w_eval_vld, w_eval_p, w_has_free, w_clash, w_accept;
    logic [POS_W-1:0]     w_req_x, w_req_y;

`ifdef CHAIN_EN
    assign w_chain = chain_hit;
`else
    logic w_unused_chain;
    assign w_chain        = '0;
    assign w_unused_chain = ^chain_hit;
`endif

    // A player is eligible only after its req has been seen low since its last ack.
    always_comb begin
        w_elig     = req & r_armed;
        w_eval_vld = |w_elig;
        w_eval_p   = (w_elig == 2'b11) ? r_rr : w_elig[1];
        w_req_x    = w_eval_p ? req_x1 : req_x0;
        w_req_y    = w_eval_p ? req_y1 : req_y0;
        w_has_free = 1'b0;
        w_clash    = 1'b0;
        w_alloc    = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (r_state[i] == S_FREE) begin
                if (!w_has_free) w_alloc[i] = 1'b1;
                w_has_free = 1'b1;
            end else if (r_x[i] == w_req_x && r_y[i] == w_req_y) begin
                w_clash = 1'b1;
            end
        end
        w_accept = w_eval_vld && w_has_free && !w_clash && (r_live[w_eval_p] < LIVE_MAX);
        if (!w_accept) w_alloc = '0;
        w_grant_n = '0;
        w_deny_n  = '0;
        w_armed_n = r_armed;
        if (w_eval_vld) begin
            if (w_accept) w_grant_n[w_eval_p] = 1'b1;
            else          w_deny_n[w_eval_p]  = 1'b1;
            w_armed_n[w_eval_p] = 1'b0;
        end
        w_armed_n = w_armed_n | ~req;
        w_rr_n    = (w_elig == 2'b11) ? ~r_rr : r_rr;
    end

    always_comb begin
        w_dec[0]    = '0;
        w_dec[1]    = '0;
        w_explode_n = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            w_state_n[i] = r_state[i];
            w_cnt_n[i]   = r_cnt[i];
            w_owner_n[i] = r_owner[i];
            w_x_n[i]     = r_x[i];
            w_y_n[i]     = r_y[i];
            case (r_state[i])
                S_FREE: begin
                    if (w_alloc[i]) begin
                        w_state_n[i] = S_FUSE;
                        w_cnt_n[i]   = FUSE_LOAD;
                        w_owner_n[i] = w_eval_p;
                        w_x_n[i]     = w_req_x;
                        w_y_n[i]     = w_req_y;
                    end
                end
                S_FUSE: begin
                    if (w_chain[i] || (frame_tick && r_cnt[i] == 8'd0)) begin
                        w_state_n[i]   = S_EXPLODE;
                        w_cnt_n[i]     = EXP_LOAD;
                        w_explode_n[i] = 1'b1;
                    end else if (frame_tick) begin
                        w_cnt_n[i] = r_cnt[i] - 8'd1;
                    end
                end
                S_EXPLODE: begin
                    if (frame_tick) begin
                        if (r_cnt[i] == 8'd0) w_state_n[i] = S_DONE;
                        else                  w_cnt_n[i]   = r_cnt[i] - 8'd1;
                    end
                end
                default: begin
                    w_state_n[i] = S_FREE;
                    w_dec[r_owner[i]] = w_dec[r_owner[i]] + LIVE_ONE;
                end
            endcase
        end
        // Increment and decrement of one player in one cycle cancel naturally here.
        w_live_n[0] = r_live[0] - w_dec[0] + ((w_accept && !w_eval_p) ? LIVE_ONE : '0);
        w_live_n[1] = r_live[1] - w_dec[1] + ((w_accept &&  w_eval_p) ? LIVE_ONE : '0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= S_FREE;
                r_cnt[i]   <= '0;
                r_owner[i] <= 1'b0;
                r_x[i]     <= '0;
                r_y[i]     <= '0;
            end
            r_live[0] <= '0;
            r_live[1] <= '0;
            r_explode <= '0;
            r_grant   <= '0;
            r_deny    <= '0;
            r_armed   <= '1;
            r_rr      <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= w_state_n[i];
                r_cnt[i]   <= w_cnt_n[i];
                r_owner[i] <= w_owner_n[i];
                r_x[i]     <= w_x_n[i];
                r_y[i]     <= w_y_n[i];
            end
            r_live[0] <= w_live_n[0];
            r_live[1] <= w_live_n[1];
            r_explode <= w_explode_n;
            r_grant   <= w_grant_n;
            r_deny    <= w_deny_n;
            r_armed   <= w_armed_n;
            r_rr      <= w_rr_n;
        end
    end

    assign grant         = r_grant;
    assign deny          = r_deny;
    assign explode_start = r_explode;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
        assign slot_state[2*g +: 2]         = r_state[g];
        assign slot_owner[g]                = r_owner[g];
        assign slot_x[POS_W*g +: POS_W]     = r_x[g];
        assign slot_y[POS_W*g +: POS_W]     = r_y[g];
    end
endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler: ack scoreboard plus per-step state checks.
module tb_bomb_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ft = 1'b0;
    logic [1:0]  req = '0;
    logic [4:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [1:0]  grant, deny;
    logic [7:0]  slot_state;
    logic [3:0]  slot_owner;
    logic [19:0] slot_x, slot_y;
    logic [3:0]  explode_start;
    logic [3:0]  chain_hit = '0;

    int total = 0;
    int bad = 0;
    logic [3:0] exp_q [$];

    bomb_scheduler #(
        .NUM_SLOTS(4), .MAX_PER_PLAYER(2), .FUSE_FRAMES(80), .EXPLODE_FRAMES(10), .POS_W(5)
    ) dut (
        .Clk(clk), .Reset(rst), .frame_tick(ft), .req(req),
        .req_x0(x0), .req_y0(y0), .req_x1(x1), .req_y1(y1),
        .grant(grant), .deny(deny), .slot_state(slot_state), .slot_owner(slot_owner),
        .slot_x(slot_x), .slot_y(slot_y), .explode_start(explode_start), .chain_hit(chain_hit)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] st(int i);
        return slot_state[2*i +: 2];
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Every cycle advance goes through here so any grant/deny is matched to the queue.
    task automatic step();
        logic [3:0] got, want;
        @(negedge clk);
        got = {grant, deny};
        if (got != 4'b0) begin
            want = 4'b0;
            if (exp_q.size() > 0) want = exp_q.pop_front();
            total++;
            assert (got === want) else begin
                bad++;
                $error("FAIL ack got=%b want=%b", got, want);
            end
        end
    endtask

    task automatic frames(int n);
        repeat (n) begin
            ft = 1'b1; step();
            ft = 1'b0; step();
        end
    endtask

    task automatic place(int p, logic [4:0] x, logic [4:0] y, bit want_grant);
        exp_q.push_back(want_grant ? (4'b0100 << p) : (4'b0001 << p));
        if (p == 0) begin x0 = x; y0 = y; end
        else        begin x1 = x; y1 = y; end
        req[p] = 1'b1;
        step();
        chk("ack_latency", 32'((grant[p] | deny[p])), 32'd1);
        req[p] = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1; step();
        rst = 1'b0; step();
    endtask

    initial begin
        // 1: reset and a full bomb lifetime
        repeat (2) step();
        chk("rst_state", 32'(slot_state), 32'h0);
        chk("rst_owner", 32'(slot_owner), 32'h0);
        chk("rst_xy", 32'(slot_x | slot_y), 32'h0);
        chk("rst_ack", 32'({grant, deny, explode_start}), 32'h0);
        rst = 1'b0; step();
        place(0, 5'd3, 5'd4, 1'b1);
        chk("t1_fuse", 32'(st(0)), 32'd1);
        chk("t1_owner", 32'(slot_owner[0]), 32'd0);
        chk("t1_x", 32'(slot_x[4:0]), 32'd3);
        chk("t1_y", 32'(slot_y[4:0]), 32'd4);
        frames(79);
        chk("t1_fuse79", 32'(st(0)), 32'd1);
        ft = 1'b1; step(); ft = 1'b0;
        chk("t1_expl_pulse", 32'(explode_start), 32'b0001);
        chk("t1_explode", 32'(st(0)), 32'd2);
        step();
        chk("t1_expl_pulse_end", 32'(explode_start), 32'b0000);
        frames(9);
        chk("t1_explode9", 32'(st(0)), 32'd2);
        ft = 1'b1; step(); ft = 1'b0;
        chk("t1_done", 32'(st(0)), 32'd3);
        step();
        chk("t1_free", 32'(st(0)), 32'd0);

        // 2: same-tile rejection
        place(0, 5'd3, 5'd4, 1'b1);
        place(1, 5'd3, 5'd4, 1'b0);
        place(1, 5'd5, 5'd4, 1'b1);
        chk("t2_slot1", 32'(st(1)), 32'd1);
        chk("t2_owner1", 32'(slot_owner[1]), 32'd1);
        chk("t2_x1", 32'(slot_x[9:5]), 32'd5);
        do_reset();

        // 3: per-player limit, released when the first bomb frees
        place(0, 5'd1, 5'd1, 1'b1);
        frames(40);
        place(0, 5'd2, 5'd1, 1'b1);
        chk("t3_slot1", 32'(st(1)), 32'd1);
        place(0, 5'd3, 5'd1, 1'b0);
        frames(50);
        chk("t3_freed", 32'({st(1), st(0)}), 32'b0100);
        place(0, 5'd3, 5'd1, 1'b1);
        chk("t3_reuse", 32'(st(0)), 32'd1);
        chk("t3_reuse_x", 32'(slot_x[4:0]), 32'd3);
        do_reset();

        // 4: both players requesting, round-robin and pool full
        x0 = 5'd1; y0 = 5'd9; x1 = 5'd2; y1 = 5'd9;
        exp_q.push_back(4'b0100); req = 2'b11; step();
        req[0] = 1'b0; exp_q.push_back(4'b1000); step();
        req[1] = 1'b0; x0 = 5'd3; req[0] = 1'b1; exp_q.push_back(4'b0100); step();
        req[0] = 1'b0; x1 = 5'd4; req[1] = 1'b1; exp_q.push_back(4'b1000); step();
        req[1] = 1'b0; x0 = 5'd5; req[0] = 1'b1; exp_q.push_back(4'b0001); step();
        req[0] = 1'b0; step();
        chk("t4_full", 32'(slot_state), 32'h55);
        chk("t4_owners", 32'(slot_owner), 32'b1010);
        frames(89);
        ft = 1'b1; step(); ft = 1'b0;
        chk("t4_all_done", 32'(slot_state), 32'hFF);
        x0 = 5'd20; y0 = 5'd1; req[0] = 1'b1; exp_q.push_back(4'b0001); step();
        chk("t4_all_free", 32'(slot_state), 32'h00);
        req[0] = 1'b0; step();
        place(0, 5'd20, 5'd1, 1'b1);
        chk("t4_regrant", 32'(st(0)), 32'd1);
        do_reset();

        // 5: reset mid-explosion
        place(0, 5'd6, 5'd6, 1'b1);
        frames(84);
        chk("t5_exploding", 32'(st(0)), 32'd2);
        rst = 1'b1; step();
        chk("t5_rst_state", 32'(slot_state), 32'h0);
        chk("t5_rst_pulses", 32'({grant, deny, explode_start}), 32'h0);
        rst = 1'b0; step();
        place(0, 5'd6, 5'd6, 1'b1);
        chk("t5_slot0", 32'(st(0)), 32'd1);
        place(0, 5'd7, 5'd6, 1'b1);
        chk("t5_slot1", 32'(st(1)), 32'd1);
        do_reset();

        // 6: chain_hit on a fusing bomb
        place(0, 5'd1, 5'd2, 1'b1);
        place(1, 5'd2, 5'd2, 1'b1);
        frames(29);
        chk("t6_fuse", 32'(st(1)), 32'd1);
        chain_hit = 4'b0010; step(); chain_hit = '0;
`ifdef CHAIN_EN
        chk("t6_chain_pulse", 32'(explode_start), 32'b0010);
        chk("t6_chain_state", 32'(st(1)), 32'd2);
`else
        chk("t6_no_chain", 32'(explode_start), 32'b0000);
        chk("t6_still_fuse", 32'(st(1)), 32'd1);
        frames(50);
        chk("t6_fuse50", 32'(st(1)), 32'd1);
        ft = 1'b1; step(); ft = 1'b0;
        chk("t6_expire", 32'(explode_start), 32'b0011);
`endif
        step();
        chk("ack_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
